// File: rtl/fu_wb_arbiter_pkg.sv
// Shared parameters and payload type for the FU writeback arbiter.
// Holds default sizes and the packed result packet used by the
// holding slots and the CDB register.
package wb_pkg;

    localparam int unsigned WB_NUM_FU = 4;
    localparam int unsigned WB_DATA_W = 64;
    localparam int unsigned WB_PRN_W  = 7;
    localparam int unsigned WB_ID_W   = 6;

    // One writeback result; data[2] carries NZCV in bits 3:0.
    typedef struct packed {
        logic [WB_ID_W-1:0]             inst_id;
        logic [WB_PRN_W-1:0]            prn;
        logic [2:0][WB_DATA_W-1:0]      data;
        logic [2:0]                     data_valid;
    } wb_pkt_t;

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// FU-to-CDB writeback bus.
// FU side : fu_out_valid/inst_id/prn/data/data_valid in, fu_ready out.
// CDB side: cdb_ready in, cdb_valid/inst_id/prn/data/data_valid out.
// slave modport is the arbiter view, master modport the producer/consumer view.
interface fu_wb_arbiter_if #(
    parameter int unsigned NUM_FU = wb_pkg::WB_NUM_FU
);
    logic [NUM_FU-1:0]                              fu_out_valid;
    logic [NUM_FU-1:0][wb_pkg::WB_ID_W-1:0]         fu_out_inst_id;
    logic [NUM_FU-1:0][wb_pkg::WB_PRN_W-1:0]        fu_out_prn;
    logic [NUM_FU-1:0][2:0][wb_pkg::WB_DATA_W-1:0]  fu_out_data;
    logic [NUM_FU-1:0][2:0]                         fu_out_data_valid;
    logic [NUM_FU-1:0]                              fu_ready;

    logic                                           cdb_ready;
    logic                                           cdb_valid;
    logic [wb_pkg::WB_ID_W-1:0]                     cdb_inst_id;
    logic [wb_pkg::WB_PRN_W-1:0]                    cdb_prn;
    logic [2:0][wb_pkg::WB_DATA_W-1:0]              cdb_data;
    logic [2:0]                                     cdb_data_valid;

    modport slave (
        input  fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
        output fu_ready,
        input  cdb_ready,
        output cdb_valid, cdb_inst_id, cdb_prn, cdb_data, cdb_data_valid
    );

    modport master (
        output fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
        input  fu_ready,
        output cdb_ready,
        input  cdb_valid, cdb_inst_id, cdb_prn, cdb_data, cdb_data_valid
    );
endinterface

// File: rtl/fu_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// req    : request vector
// rr_ptr : highest-priority index
// en     : grant enable (zero grant when low)
// grant  : one-hot grant, lowest requesting index >= rr_ptr, wrapping
module rr_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PTR_W-1:0]  rr_ptr,
    input  logic              en,
    output logic [NUM_FU-1:0] grant
);

    // Scan from rr_ptr upward, modulo NUM_FU; first hit wins.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % int'(NUM_FU));
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: one holding slot per FU, round-robin onto a single CDB.
// Ports: clk, rst (async, active-low), flush, bus (fu_wb_arbiter_if.slave),
//        perf_stall_cnt (per-FU back-pressure counters, only when the
//        WB_ARB_PERF_EN macro is defined).
module fu_wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_FU = WB_NUM_FU
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    fu_wb_arbiter_if.slave            bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [NUM_FU-1:0][31:0]   perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] full_q, full_d;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] fu_ready_c;
    logic [NUM_FU-1:0] capture;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  gidx;
    logic              cdb_valid_q, cdb_valid_d;
    logic              cdb_advance;
    wb_pkt_t           cdb_q, cdb_d;
    wb_pkt_t           slot_q [NUM_FU];
    wb_pkt_t           fu_pkt [NUM_FU];

    // Pack per-FU bus fields into the slot payload format.
    always_comb begin
        for (int i = 0; i < int'(NUM_FU); i++) begin
            fu_pkt[i].inst_id    = bus.fu_out_inst_id[i];
            fu_pkt[i].prn        = bus.fu_out_prn[i];
            fu_pkt[i].data       = bus.fu_out_data[i];
            fu_pkt[i].data_valid = bus.fu_out_data_valid[i];
        end
    end

    assign cdb_advance = !cdb_valid_q || bus.cdb_ready;

    rr_arbiter #(
        .NUM_FU (NUM_FU),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req    (full_q),
        .rr_ptr (rr_ptr_q),
        .en     (cdb_advance),
        .grant  (grant)
    );

    // A draining slot can refill in the same cycle.
    assign fu_ready_c = ~full_q | grant;
    assign capture    = bus.fu_out_valid & fu_ready_c & {NUM_FU{!flush}};

    // Encode the one-hot grant.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            if (grant[i]) gidx = PTR_W'(i);
        end
    end

    // Next-state for slot flags, pointer and CDB register; flush wins.
    always_comb begin
        full_d      = (full_q & ~grant) | capture;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_d       = cdb_q;
        if (|grant) begin
            cdb_d       = slot_q[gidx];
            cdb_valid_d = 1'b1;
            rr_ptr_d    = (gidx == PTR_W'(NUM_FU - 1)) ? '0 : gidx + PTR_W'(1);
        end else if (bus.cdb_ready) begin
            cdb_valid_d = 1'b0;
        end
        if (flush) begin
            full_d      = '0;
            cdb_valid_d = 1'b0;
            rr_ptr_d    = rr_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q      <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
            for (int i = 0; i < int'(NUM_FU); i++) slot_q[i] <= '0;
        end else begin
            full_q      <= full_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (capture[i]) slot_q[i] <= fu_pkt[i];
            end
        end
    end

    assign bus.fu_ready       = fu_ready_c;
    assign bus.cdb_valid      = cdb_valid_q;
    assign bus.cdb_inst_id    = cdb_q.inst_id;
    assign bus.cdb_prn        = cdb_q.prn;
    assign bus.cdb_data       = cdb_q.data;
    assign bus.cdb_data_valid = cdb_q.data_valid;

`ifdef WB_ARB_PERF_EN
    // Saturating count of cycles an FU was held off; cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (bus.fu_out_valid[i] && !fu_ready_c[i] && (perf_stall_cnt[i] != '1))
                    perf_stall_cnt[i] <= perf_stall_cnt[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fu_wb_arbiter.sv
module tb_fu_wb_arbiter;
    import wb_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   n_checks;
    int   n_fail;

    fu_wb_arbiter_if #(.NUM_FU(4)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [3:0][31:0] perf;
`endif

    fu_wb_arbiter #(.NUM_FU(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fu_out_valid      = '0;
        bus.fu_out_inst_id    = '0;
        bus.fu_out_prn        = '0;
        bus.fu_out_data       = '0;
        bus.fu_out_data_valid = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        flush    = 1'b0;
        rst      = 1'b1;
        bus.cdb_ready = 1'b1;
        clear_inputs();

        // Reset state
        #2 rst = 1'b0;
        #1;
        check_eq("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        check_eq("rst_fu_ready",  64'(bus.fu_ready),  64'hF);
        check_eq("rst_cdb_id",    64'(bus.cdb_inst_id), 64'd0);
        check_eq("rst_cdb_data0", 64'(bus.cdb_data[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single FU1 result, two-cycle latency
        bus.fu_out_valid         = 4'b0010;
        bus.fu_out_inst_id[1]    = 6'd5;
        bus.fu_out_prn[1]        = 7'd12;
        bus.fu_out_data[1][0]    = 64'h1234;
        bus.fu_out_data_valid[1] = 3'b001;
        step();
        clear_inputs();
        check_eq("t1_ready_c1", 64'(bus.fu_ready),  64'hF);
        check_eq("t1_valid_c1", 64'(bus.cdb_valid), 64'd0);
        step();
        check_eq("t1_valid_c2", 64'(bus.cdb_valid),      64'd1);
        check_eq("t1_id",       64'(bus.cdb_inst_id),    64'd5);
        check_eq("t1_prn",      64'(bus.cdb_prn),        64'd12);
        check_eq("t1_data0",    64'(bus.cdb_data[0]),    64'h1234);
        check_eq("t1_dv",       64'(bus.cdb_data_valid), 64'b001);
        check_eq("t1_ready_c2", 64'(bus.fu_ready),       64'hF);
        step();
        check_eq("t1_valid_c3", 64'(bus.cdb_valid), 64'd0);

        // Reset pulse between edges returns rr_ptr to 0
        rst = 1'b0;
        #1 rst = 1'b1;

        // All four FUs in one cycle: order 0,1,2,3
        for (int i = 0; i < 4; i++) bus.fu_out_inst_id[i] = 6'(10 + i);
        bus.fu_out_valid = 4'hF;
        step();
        clear_inputs();
        check_eq("t2_ready_c1", 64'(bus.fu_ready), 64'b0001);
        step();
        check_eq("t2_id_c2",    64'(bus.cdb_inst_id), 64'd10);
        check_eq("t2_ready_c2", 64'(bus.fu_ready),    64'b0011);
        step();
        check_eq("t2_id_c3",    64'(bus.cdb_inst_id), 64'd11);
        check_eq("t2_ready_c3", 64'(bus.fu_ready),    64'b0111);
        step();
        check_eq("t2_id_c4",    64'(bus.cdb_inst_id), 64'd12);
        check_eq("t2_ready_c4", 64'(bus.fu_ready),    64'b1111);
        step();
        check_eq("t2_id_c5",    64'(bus.cdb_inst_id), 64'd13);
        check_eq("t2_valid_c5", 64'(bus.cdb_valid),   64'd1);
        step();
        check_eq("t2_valid_c6", 64'(bus.cdb_valid),   64'd0);

        // FU2 streaming at one result per cycle
        for (int k = 0; k < 7; k++) begin
            bus.fu_out_valid      = (k < 5) ? 4'b0100 : 4'b0000;
            bus.fu_out_inst_id[2] = 6'(20 + k);
            step();
            check_eq("t3_ready", 64'(bus.fu_ready), 64'hF);
            if (k >= 1 && k <= 5) begin
                check_eq("t3_valid", 64'(bus.cdb_valid),   64'd1);
                check_eq("t3_id",    64'(bus.cdb_inst_id), 64'(20 + k - 1));
            end
            if (k == 6) check_eq("t3_valid_end", 64'(bus.cdb_valid), 64'd0);
        end
        clear_inputs();

        // CDB stall holds payload; next grant follows ready
        bus.fu_out_valid      = 4'b0011;
        bus.fu_out_inst_id[0] = 6'd7;
        bus.fu_out_inst_id[1] = 6'd8;
        step();
        clear_inputs();
        check_eq("t4_ready_c1", 64'(bus.fu_ready), 64'b1101);
        step();
        check_eq("t4_id_c2", 64'(bus.cdb_inst_id), 64'd7);
        bus.cdb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("t4_hold_valid", 64'(bus.cdb_valid),   64'd1);
            check_eq("t4_hold_id",    64'(bus.cdb_inst_id), 64'd7);
            check_eq("t4_hold_ready", 64'(bus.fu_ready),    64'b1101);
        end
        bus.cdb_ready = 1'b1;
        step();
        check_eq("t4_next_id", 64'(bus.cdb_inst_id), 64'd8);
        step();
        check_eq("t4_valid_end", 64'(bus.cdb_valid), 64'd0);

        // Flush with slots 0 and 3 full and FU1 presenting
        bus.cdb_ready         = 1'b0;
        bus.fu_out_valid      = 4'b1001;
        bus.fu_out_inst_id[0] = 6'd40;
        bus.fu_out_inst_id[3] = 6'd43;
        step();
        check_eq("t5_ready_c1", 64'(bus.fu_ready), 64'b1110);
        bus.fu_out_valid      = 4'b1000;
        bus.fu_out_inst_id[3] = 6'd44;
        step();
        check_eq("t5_id_c2",    64'(bus.cdb_inst_id), 64'd43);
        check_eq("t5_ready_c2", 64'(bus.fu_ready),    64'b0110);
        flush                 = 1'b1;
        bus.fu_out_valid      = 4'b0010;
        bus.fu_out_inst_id[1] = 6'd45;
        step();
        flush = 1'b0;
        clear_inputs();
        bus.cdb_ready = 1'b1;
        check_eq("t5_flush_valid", 64'(bus.cdb_valid), 64'd0);
        check_eq("t5_flush_ready", 64'(bus.fu_ready),  64'hF);
        step();
        check_eq("t5_drop_valid1", 64'(bus.cdb_valid), 64'd0);
        step();
        check_eq("t5_drop_valid2", 64'(bus.cdb_valid), 64'd0);

        // FU0 back-pressured for four cycles, then reset mid-transfer
        bus.cdb_ready         = 1'b0;
        bus.fu_out_valid      = 4'b0011;
        bus.fu_out_inst_id[0] = 6'd50;
        bus.fu_out_inst_id[1] = 6'd51;
        step();
        check_eq("t6_ready_c1", 64'(bus.fu_ready), 64'b1101);
        bus.fu_out_valid      = 4'b0001;
        bus.fu_out_inst_id[0] = 6'd52;
        step();
        check_eq("t6_id_c2", 64'(bus.cdb_inst_id), 64'd50);
        for (int k = 0; k < 4; k++) begin
            check_eq("t6_stall_ready0", 64'(bus.fu_ready[0]), 64'd0);
            step();
        end
        clear_inputs();
`ifdef WB_ARB_PERF_EN
        check_eq("t6_perf0", 64'(perf[0]), 64'd4);
        check_eq("t6_perf1", 64'(perf[1]), 64'd0);
`endif
        check_eq("t6_held_valid", 64'(bus.cdb_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_rst_valid", 64'(bus.cdb_valid), 64'd0);
        check_eq("t6_rst_ready", 64'(bus.fu_ready),  64'hF);
        check_eq("t6_rst_id",    64'(bus.cdb_inst_id), 64'd0);
`ifdef WB_ARB_PERF_EN
        check_eq("t6_rst_perf0", 64'(perf[0]), 64'd0);
`endif
        rst                   = 1'b1;
        bus.cdb_ready         = 1'b1;
        bus.fu_out_valid      = 4'b0100;
        bus.fu_out_inst_id[2] = 6'd33;
        step();
        clear_inputs();
        check_eq("t6_post_ready", 64'(bus.fu_ready), 64'hF);
        step();
        check_eq("t6_post_valid", 64'(bus.cdb_valid),   64'd1);
        check_eq("t6_post_id",    64'(bus.cdb_inst_id), 64'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
